// File: rtl/s_axis_rq_arb_pkg.sv
// Shared definitions for the RQ stream arbiter: tuser bit positions and the
// requester port encoding used for owner / last-served tracking.
package s_axis_rq_arb_pkg;

  localparam int TUSER_ECRC        = 0;
  localparam int TUSER_POISON      = 1;
  localparam int TUSER_DISCONTINUE = 3;

  typedef enum logic {
    PORT_RD = 1'b0,
    PORT_WR = 1'b1
  } port_e;

  function automatic logic [1:0] port_onehot(input port_e p);
    return (p == PORT_WR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/s_axis_rq_arb_skid.sv
// One-entry output register plus one-entry skid buffer: every output and the
// upstream ready come straight from flops, with full throughput.
module axis_skid_slice #(
  parameter int DAT_B = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DAT_B-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DAT_B-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [DAT_B-1:0] m_data_reg, m_data_next;
  logic [DAT_B-1:0] skid_data_reg, skid_data_next;
  logic             m_valid_reg, m_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             ready_reg, ready_next;
  logic             in_fire;

  assign in_fire = s_valid && ready_reg;

  always_comb begin
    m_data_next     = m_data_reg;
    m_valid_next    = m_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_valid_next = skid_valid_reg;
    if (m_ready || !m_valid_reg) begin
      // ready is low whenever the skid holds a beat, so no input can arrive here
      if (skid_valid_reg) begin
        m_data_next     = skid_data_reg;
        m_valid_next    = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        m_valid_next = in_fire;
        if (in_fire) begin
          m_data_next = s_data;
        end
      end
    end else if (in_fire) begin
      skid_data_next  = s_data;
      skid_valid_next = 1'b1;
    end
    ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_reg     <= '0;
      m_valid_reg    <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      m_data_reg     <= m_data_next;
      m_valid_reg    <= m_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
    end
  end

  assign s_ready = ready_reg;
  assign m_data  = m_data_reg;
  assign m_valid = m_valid_reg;

endmodule

// File: rtl/s_axis_rq_arb.sv
// Packet-level 2:1 round-robin merge of the DMA read and write requester
// streams onto the single RQ stream; packets are never interleaved.
module s_axis_rq_arb
  import s_axis_rq_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 4
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            gnt_o
);

  localparam int DAT_B = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  port_e            sel;
  port_e            owner_reg, owner_next;
  port_e            last_reg, last_next;
  logic             locked_reg, locked_next;
  logic [1:0]       gnt_reg, gnt_next;
  logic             slice_rdy, in_valid, in_last, in_fire;
  logic [DAT_B-1:0] in_beat, out_beat;

  // A locked packet keeps its port; otherwise alternate when both ask.
  always_comb begin
    sel = PORT_RD;
    if (locked_reg) begin
      sel = owner_reg;
    end else if (s0_axis_tvalid && s1_axis_tvalid) begin
      sel = (last_reg == PORT_RD) ? PORT_WR : PORT_RD;
    end else if (s1_axis_tvalid) begin
      sel = PORT_WR;
    end
  end

  assign s0_axis_tready = slice_rdy && (sel == PORT_RD);
  assign s1_axis_tready = slice_rdy && (sel == PORT_WR);

  assign in_valid = (sel == PORT_WR) ? s1_axis_tvalid : s0_axis_tvalid;
  assign in_last  = (sel == PORT_WR) ? s1_axis_tlast  : s0_axis_tlast;
  assign in_fire  = in_valid && slice_rdy;
  assign in_beat  = (sel == PORT_WR)
                  ? {s1_axis_tdata, s1_axis_tkeep, s1_axis_tuser, s1_axis_tlast}
                  : {s0_axis_tdata, s0_axis_tkeep, s0_axis_tuser, s0_axis_tlast};

  always_comb begin
    locked_next = locked_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    if (in_fire) begin
      if (in_last) begin
        locked_next = 1'b0;
        last_next   = sel;
      end else begin
        locked_next = 1'b1;
        owner_next  = sel;
      end
    end
    gnt_next = locked_next ? port_onehot(owner_next) : 2'b00;
  end

  // last_served starts at the write port so the read port wins first.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      locked_reg <= 1'b0;
      owner_reg  <= PORT_RD;
      last_reg   <= PORT_WR;
      gnt_reg    <= 2'b00;
    end else begin
      locked_reg <= locked_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
      gnt_reg    <= gnt_next;
    end
  end

  assign gnt_o = gnt_reg;

  axis_skid_slice #(
    .DAT_B (DAT_B)
  ) u_slice (
    .clk     (user_clk),
    .rst_n   (user_reset_n),
    .s_data  (in_beat),
    .s_valid (in_valid),
    .s_ready (slice_rdy),
    .m_data  (out_beat),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_beat;

endmodule

// File: tb/tb_s_axis_rq_arb.sv
// Scoreboard bench for s_axis_rq_arb: per-port expected queues filled by the
// drivers, drained by an output monitor that also models the lock/grant state.
module tb_s_axis_rq_arb;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 4;
  localparam int BW = DW + KW + UW + 1;
  typedef logic [BW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata [2];
  logic [KW-1:0] s_tkeep [2];
  logic [UW-1:0] s_tuser [2];
  logic          s_tlast [2];
  logic          s_tvalid [2];
  logic          s0_tready, s1_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tlast, m_tvalid;
  logic          m_tready = 1'b1;
  logic [1:0]    gnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit abort = 0;
  bit rand_rdy = 0;

  beat_t sb0[$];
  beat_t sb1[$];
  int    mo_q[$];
  int    acc0 = 0, acc1 = 0;
  int    fire_cnt = 0, first_cyc = 0, last_cyc = 0;

  s_axis_rq_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .user_clk       (clk),
    .user_reset_n   (rst_n),
    .s0_axis_tdata  (s_tdata[0]),
    .s0_axis_tkeep  (s_tkeep[0]),
    .s0_axis_tlast  (s_tlast[0]),
    .s0_axis_tuser  (s_tuser[0]),
    .s0_axis_tvalid (s_tvalid[0]),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s_tdata[1]),
    .s1_axis_tkeep  (s_tkeep[1]),
    .s1_axis_tlast  (s_tlast[1]),
    .s1_axis_tuser  (s_tuser[1]),
    .s1_axis_tvalid (s_tvalid[1]),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .gnt_o          (gnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t pack(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic [UW-1:0] u, input logic l);
    return {d, k, u, l};
  endfunction

  // Presents one packet on port p; returns early on abort (reset mid-packet).
  task automatic send_pkt(input int p, input int len, input int gap_max, input bit a5);
    logic [DW-1:0] d;
    beat_t b_exp;
    int to;
    bit done;
    for (int b = 0; b < len; b++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        repeat (g) begin
          s_tvalid[p] = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      d = (a5 && b == len - 1) ? {16{8'hA5}} : {$urandom(), $urandom(), $urandom(), $urandom()};
      s_tdata[p]  = d;
      s_tkeep[p]  = KW'($urandom());
      s_tuser[p]  = UW'($urandom());
      s_tlast[p]  = (b == len - 1);
      s_tvalid[p] = 1'b1;
      b_exp = pack(s_tdata[p], s_tkeep[p], s_tuser[p], s_tlast[p]);
      if (p == 0) sb0.push_back(b_exp);
      else        sb1.push_back(b_exp);
      to = 0;
      done = 0;
      while (!done) begin
        @(negedge clk);
        if (abort) begin
          s_tvalid[p] = 1'b0;
          return;
        end
        if ((p == 0) ? s0_tready : s1_tready) begin
          @(posedge clk);
          #1;
          done = 1;
        end else if (++to > 4000) begin
          check_value("drv_timeout", 0, 1);
          s_tvalid[p] = 1'b0;
          return;
        end
      end
    end
    s_tvalid[p] = 1'b0;
  endtask

  task automatic wait_drain();
    int to;
    to = 0;
    while ((sb0.size() != 0 || sb1.size() != 0 || m_tvalid) && to < 5000) begin
      @(posedge clk);
      to++;
    end
    check_value("drain", to < 5000, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int p, input int n);
    int start, to;
    start = (p == 0) ? acc0 : acc1;
    to = 0;
    while ((((p == 0) ? acc0 : acc1) - start) < n && to < 200) begin
      @(posedge clk);
      to++;
    end
    check_value("acc_wait", to < 200, 1);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(1, 0));
  end

  // Output monitor and reference model of the arbitration state.
  bit    mlocked, mowner, mlast, pend_lat, prev_stall;
  beat_t pend_beat, prev_beat;
  int    m_cur_port;

  initial forever begin
    beat_t mb, ib;
    int p;
    bit rdy;
    @(negedge clk);
    if (!rst_n) begin
      mlocked = 0; mowner = 0; mlast = 1;
      pend_lat = 0; prev_stall = 0; m_cur_port = -1;
    end else begin
      mb = pack(m_tdata, m_tkeep, m_tuser, m_tlast);
      if (prev_stall) check_value("m_stable", {m_tvalid, mb}, {1'b1, prev_beat});
      if (pend_lat)   check_value("latency_1cyc", {m_tvalid, mb}, {1'b1, pend_beat});
      check_value("gnt", gnt, mlocked ? (mowner ? 2'b10 : 2'b01) : 2'b00);
      check_value("tready_excl", s0_tready & s1_tready, 0);
      if (mlocked)
        check_value("lock_block", mowner ? s0_tready : s1_tready, 0);
      else if (s_tvalid[0] && s_tvalid[1] && (s0_tready || s1_tready))
        check_value("rr_pick", s1_tready, !mlast);

      if (m_tvalid && m_tready) begin
        p = -1;
        if (sb0.size() != 0 && sb0[0] == mb) p = 0;
        else if (sb1.size() != 0 && sb1[0] == mb) p = 1;
        if (p == 0)      check_value("sb_payload", mb, sb0.pop_front());
        else if (p == 1) check_value("sb_payload", mb, sb1.pop_front());
        else check_value("sb_unexpected", {1'b1, mb},
                         {1'b0, (sb0.size() != 0) ? sb0[0] : ((sb1.size() != 0) ? sb1[0] : beat_t'(0))});
        if (p >= 0) begin
          fire_cnt++;
          if (fire_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
          if (m_cur_port != -1) check_value("no_interleave", p, m_cur_port);
          else mo_q.push_back(p);
          m_cur_port = m_tlast ? -1 : p;
          $display("beat port%0d last=%0d cyc=%0d", p, m_tlast, cyc);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = mb;

      pend_lat = 0;
      for (int i = 0; i < 2; i++) begin
        rdy = (i == 0) ? s0_tready : s1_tready;
        if (s_tvalid[i] && rdy) begin
          ib = pack(s_tdata[i], s_tkeep[i], s_tuser[i], s_tlast[i]);
          pend_lat  = !m_tvalid || m_tready;
          pend_beat = ib;
          if (i == 0) acc0++;
          else        acc1++;
          if (!s_tlast[i]) begin
            mlocked = 1;
            mowner  = 1'(i);
          end else begin
            mlocked = 0;
            mlast   = 1'(i);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i] = '0; s_tkeep[i] = '0; s_tuser[i] = '0;
      s_tlast[i] = 1'b0; s_tvalid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_m_tvalid", m_tvalid, 0);
    check_value("rst_m_beat", pack(m_tdata, m_tkeep, m_tuser, m_tlast), 0);
    check_value("rst_gnt", gnt, 0);
    check_value("rst_s0_tready", s0_tready, 0);
    check_value("rst_s1_tready", s1_tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3-beat packet on port 0
    mo_q.delete();
    send_pkt(0, 3, 0, 1);
    wait_drain();
    check_value("t1_pkts", mo_q.size(), 1);

    // both ports saturated: port 0 first, strict alternation, no bubbles
    do_reset();
    mo_q.delete();
    fire_cnt = 0;
    fork
      begin send_pkt(0, 4, 0, 0); send_pkt(0, 4, 0, 0); end
      begin send_pkt(1, 4, 0, 0); send_pkt(1, 4, 0, 0); end
    join
    wait_drain();
    ord = 0;
    foreach (mo_q[i]) ord = ord * 2 + mo_q[i];
    check_value("t2_npkts", mo_q.size(), 4);
    check_value("t2_order", ord, 5);
    check_value("t2_no_bubble", last_cyc - first_cyc, 15);

    // port 1 arrives mid-packet on port 0
    mo_q.delete();
    fork
      send_pkt(0, 4, 0, 0);
      begin wait_acc(0, 2); send_pkt(1, 2, 0, 0); end
    join
    wait_drain();
    ord = 0;
    foreach (mo_q[i]) ord = ord * 2 + mo_q[i];
    check_value("t3_npkts", mo_q.size(), 2);
    check_value("t3_order", ord, 1);

    // single-beat packets from port 1 only
    mo_q.delete();
    fire_cnt = 0;
    for (int i = 0; i < 10; i++) send_pkt(1, 1, 0, 0);
    wait_drain();
    check_value("t4_beats", fire_cnt, 10);
    check_value("t4_npkts", mo_q.size(), 10);
    check_value("t4_b2b", last_cyc - first_cyc, 9);

    // random backpressure, both ports streaming
    rand_rdy = 1;
    fork
      repeat (500) send_pkt(0, $urandom_range(4, 1), 2, 0);
      repeat (500) send_pkt(1, $urandom_range(4, 1), 2, 0);
    join
    rand_rdy = 0;
    m_tready = 1'b1;
    wait_drain();
    check_value("t5_sb0_empty", sb0.size(), 0);
    check_value("t5_sb1_empty", sb1.size(), 0);

    // reset mid-packet
    fork
      send_pkt(0, 6, 0, 0);
    join_none
    wait_acc(0, 3);
    rst_n = 1'b0;
    abort = 1;
    #1;
    check_value("t6_m_tvalid", m_tvalid, 0);
    check_value("t6_gnt", gnt, 0);
    @(negedge clk);
    check_value("t6_s0_tready", s0_tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb0.delete();
    sb1.delete();
    abort = 0;
    @(posedge clk); #1;
    mo_q.delete();
    fire_cnt = 0;
    send_pkt(0, 3, 0, 0);
    wait_drain();
    check_value("t6_beats", fire_cnt, 3);
    check_value("t6_npkts", mo_q.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
